pred_multi: RTL and testbench
=============================

Name: pred_multi

Overview:
- Multi-channel, programmable edge-delay block for the DRSSTC controller. Next generation of the single-channel predictor.
- Each of CH asynchronous gate/feedback signals is synchronised and re-emitted after a delay. The delay is set independently per channel for rising and falling edges.
- Optional glitch cancellation, per-channel enable, and sticky glitch flags.
- Delays and control are written over the shared addr/data/en configuration bus.

Parameters:
- CH, 2, number of channels (1..8).
- DLY_W, 8, width of delay registers and of the data bus; must be >= CH+1.
- ADDR_W, 4, width of the addr bus.
- ADDR_BASE, 4, address of channel 0 rise delay.
- DLY_DEFAULT, 0, reset value of every delay register.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- sgn  in  CH  raw asynchronous input signals.
- addr  in  ADDR_W  configuration address.
- data  in  DLY_W  configuration write data.
- en  in  1  write strobe; write occurs on a clk edge with en=1.
- sgn_pre  out  CH  delayed output signals (registered).
- busy  out  CH  channel has a pending edge (state DELAY).
- glitch  out  CH  sticky flag: a pending edge was cancelled.

Behaviour:
- Reset: one clock, synchronous, active-high. The only clock is clk; the only reset is rst.
  - On reset: sgn_pre=0, busy=0, glitch=0.
  - All counters 0, all states IDLE, synchroniser flops 0.
  - Delay registers = DLY_DEFAULT; ctrl = {cancel_en=0, ch_en=all 1}.
  - Reset mid-delay discards the pending edge.
- Register map:
  - ADDR_BASE+2i = rise_dly[i].
  - ADDR_BASE+2i+1 = fall_dly[i].
  - ADDR_BASE+2CH = ctrl: bits[CH-1:0] ch_en, bit CH cancel_en. Writing ctrl also clears all glitch bits.
  - Other addresses are ignored. Writes take effect on the next clk edge.
  - A delay write during DELAY does not alter the running counter; it applies from the next edge.
- Synchroniser: two flops per channel. s[i] = synchronised sgn[i].
- Per-channel FSM, states IDLE and DELAY:
  - IDLE, s != sgn_pre: tgt <= s; D = s ? rise_dly : fall_dly.
    - D=0: sgn_pre <= s on this edge; stay IDLE.
    - D>0: cnt <= D-1, go to DELAY, busy=1.
  - DELAY, cancel_en=1 and s == sgn_pre (input reverted): go to IDLE, glitch[i] <= 1, sgn_pre unchanged.
  - DELAY otherwise:
    - cnt==0: sgn_pre <= tgt, go to IDLE.
    - else cnt <= cnt-1.
  - With cancel_en=0, reversals during DELAY are ignored. Output still toggles to tgt; IDLE then services the new level.
- Latency: sgn_pre changes D+1 clocks after s changes, i.e. D+2 edges after the sampling edge that first captures the new sgn level.
  - Pulses shorter than the programmed delay with cancel_en=1 never appear at the output.
- Disabled channel (ch_en[i]=0): sgn_pre[i] held 0, state forced IDLE, busy 0, cnt 0.
  - On re-enable, IDLE starts with sgn_pre=0, so a high input is treated as a rising edge.
- busy[i] = (state==DELAY), registered with the state.
- Simultaneous events:
  - glitch set and ctrl write on the same edge: set wins.
  - Channels are fully independent; identical stimulus on all channels gives identical outputs.
- Delay arithmetic is unsigned DLY_W; max delay is 2^DLY_W-1 (255 clocks at default).

Test Plan:
- Reset, all delays 0, sgn[0] 0->1 → sgn_pre[0] rises 2 clocks after the capturing edge; busy stays 0.
- rise_dly[0]=5, fall_dly[0]=2, 20-clk high pulse → rise appears 7 edges after capture, fall 4 edges after capture; output high for 17 clocks.
- cancel_en=1, rise_dly[1]=10, 4-clk high glitch on sgn[1] → sgn_pre[1] stays 0, glitch[1]=1, busy[1] high 4 clocks; ctrl write clears glitch[1].
- Same glitch with cancel_en=0 → sgn_pre[1] pulses high after the delay for 1 clock, then falls after fall_dly+1 clocks; glitch[1]=0.
- Write rise_dly[0]=3 while channel 0 is in DELAY with cnt=8 → current edge completes on the old count; next rising edge uses delay 3.
- ch_en[0]=0 while sgn[0]=1 and channel 0 in DELAY → sgn_pre[0]=0 and busy[0]=0 next clock. Re-enable → rising output after rise_dly+1 clocks. rst asserted mid-delay → all outputs 0 next clock.

Source files
------------

// File: rtl/pred_multi.sv
`timescale 1ns/1ps
// pred_multi: multi-channel programmable edge-delay block.
// Each raw input is synchronised through two flops and re-emitted after a per-channel,
// per-edge-direction delay. Optional glitch cancellation drops pending edges whose input
// reverts before the delay expires, and records the event in a sticky flag.
//
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   sgn      raw asynchronous inputs, one per channel
//   addr     configuration address
//   data     configuration write data
//   en       configuration write strobe
//   sgn_pre  delayed outputs (registered)
//   busy     channel holds a pending edge
//   glitch   sticky: a pending edge was cancelled (cleared by a ctrl write)
module pred_multi #(
  parameter int unsigned CH          = 2,
  parameter int unsigned DLY_W       = 8,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned ADDR_BASE   = 4,
  parameter int unsigned DLY_DEFAULT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH-1:0]     sgn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DLY_W-1:0]  data,
  input  logic              en,
  output logic [CH-1:0]     sgn_pre,
  output logic [CH-1:0]     busy,
  output logic [CH-1:0]     glitch
);

  typedef enum logic {StIdle, StDelay} state_e;

  localparam logic [CH:0] CtrlRst = {1'b0, {CH{1'b1}}};

  logic [CH-1:0]            sync1_q, sync2_q;
  logic [CH-1:0]            pre_q, pre_d;
  logic [CH-1:0]            tgt_q, tgt_d;
  logic [CH-1:0]            glitch_q, glitch_d, glitch_set;
  logic [CH-1:0][DLY_W-1:0] cnt_q, cnt_d;
  logic [CH-1:0][DLY_W-1:0] rise_q, rise_d, fall_q, fall_d;
  logic [CH:0]              ctrl_q, ctrl_d;
  logic                     ctrl_wr;
  logic [DLY_W-1:0]         dly;
  logic [31:0]              addr_ext;
  state_e                   state_q [CH];
  state_e                   state_d [CH];

  assign addr_ext = 32'(addr);

  // Upper data bits carry no meaning for ctrl writes.
  if (DLY_W > CH + 1) begin : g_unused
    logic unused_data_hi;
    assign unused_data_hi = ^data[DLY_W-1:CH+1];
  end

  // Configuration register decode.
  always_comb begin
    rise_d  = rise_q;
    fall_d  = fall_q;
    ctrl_d  = ctrl_q;
    ctrl_wr = 1'b0;
    if (en) begin
      for (int i = 0; i < int'(CH); i++) begin
        if (addr_ext == 32'(ADDR_BASE + 2 * i)) rise_d[i] = data;
        if (addr_ext == 32'(ADDR_BASE + 2 * i + 1)) fall_d[i] = data;
      end
      if (addr_ext == 32'(ADDR_BASE + 2 * CH)) begin
        ctrl_d  = data[CH:0];
        ctrl_wr = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      pre_q    <= '0;
      tgt_q    <= '0;
      glitch_q <= '0;
      cnt_q    <= '0;
      rise_q   <= {CH{DLY_W'(DLY_DEFAULT)}};
      fall_q   <= {CH{DLY_W'(DLY_DEFAULT)}};
      ctrl_q   <= CtrlRst;
      for (int i = 0; i < int'(CH); i++) state_q[i] <= StIdle;
    end else begin
      sync1_q  <= sgn;
      sync2_q  <= sync1_q;
      pre_q    <= pre_d;
      tgt_q    <= tgt_d;
      glitch_q <= glitch_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      ctrl_q   <= ctrl_d;
      for (int i = 0; i < int'(CH); i++) state_q[i] <= state_d[i];
    end
  end

  // Next-state logic, one independent FSM per channel.
  always_comb begin
    pre_d      = pre_q;
    tgt_d      = tgt_q;
    cnt_d      = cnt_q;
    glitch_set = '0;
    dly        = '0;
    for (int i = 0; i < int'(CH); i++) begin
      state_d[i] = state_q[i];
      if (!ctrl_q[i]) begin
        // Disabled: output parked low so re-enable sees a high input as a rising edge.
        state_d[i] = StIdle;
        cnt_d[i]   = '0;
        pre_d[i]   = 1'b0;
      end else begin
        unique case (state_q[i])
          StIdle: begin
            if (sync2_q[i] != pre_q[i]) begin
              tgt_d[i] = sync2_q[i];
              dly      = sync2_q[i] ? rise_q[i] : fall_q[i];
              if (dly == '0) begin
                pre_d[i] = sync2_q[i];
              end else begin
                cnt_d[i]   = dly - DLY_W'(1);
                state_d[i] = StDelay;
              end
            end
          end
          StDelay: begin
            if (ctrl_q[CH] && (sync2_q[i] == pre_q[i])) begin
              state_d[i]    = StIdle;
              glitch_set[i] = 1'b1;
            end else if (cnt_q[i] == '0) begin
              pre_d[i]   = tgt_q[i];
              state_d[i] = StIdle;
            end else begin
              cnt_d[i] = cnt_q[i] - DLY_W'(1);
            end
          end
          default: state_d[i] = StIdle;
        endcase
      end
    end
    // A new cancellation on the same edge as a ctrl write keeps its flag.
    glitch_d = (ctrl_wr ? '0 : glitch_q) | glitch_set;
  end

  // Outputs.
  always_comb begin
    busy = '0;
    for (int i = 0; i < int'(CH); i++) busy[i] = (state_q[i] == StDelay);
  end

  assign sgn_pre = pre_q;
  assign glitch  = glitch_q;

endmodule

// File: tb/tb_pred_multi.sv
`timescale 1ns/1ps
// Directed bench for pred_multi with a timestamp-based reference model.
module tb_pred_multi;

  localparam int CH     = 2;
  localparam int DLY_W  = 8;
  localparam int ADDR_W = 4;
  localparam int ABASE  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [CH-1:0]     sgn = '0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DLY_W-1:0]  data = '0;
  logic              en = 1'b0;
  logic [CH-1:0]     sgn_pre, busy, glitch;

  int checks = 0;
  int errors = 0;

  pred_multi #(
    .CH(CH), .DLY_W(DLY_W), .ADDR_W(ADDR_W), .ADDR_BASE(ABASE), .DLY_DEFAULT(0)
  ) dut (
    .clk(clk), .rst(rst), .sgn(sgn), .addr(addr), .data(data), .en(en),
    .sgn_pre(sgn_pre), .busy(busy), .glitch(glitch)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pending edge is a (due time, target) pair.
  int unsigned      cyc = 0;
  logic [CH-1:0]    m_s1, m_s2, m_out, m_pend, m_glitch, m_tgt;
  int unsigned      m_due [CH];
  logic [DLY_W-1:0] m_rise [CH];
  logic [DLY_W-1:0] m_fall [CH];
  logic [CH:0]      m_ctrl;

  initial forever begin : model
    logic [CH-1:0]    s, setv;
    logic [DLY_W-1:0] d;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_out = '0; m_pend = '0; m_glitch = '0; m_tgt = '0;
      m_ctrl = {1'b0, {CH{1'b1}}};
      for (int c = 0; c < CH; c++) begin
        m_rise[c] = '0; m_fall[c] = '0; m_due[c] = 0;
      end
    end else begin
      s = m_s2;
      setv = '0;
      for (int c = 0; c < CH; c++) begin
        if (!m_ctrl[c]) begin
          m_out[c] = 1'b0;
          m_pend[c] = 1'b0;
        end else if (m_pend[c]) begin
          if (m_ctrl[CH] && s[c] == m_out[c]) begin
            m_pend[c] = 1'b0;
            setv[c] = 1'b1;
          end else if (cyc >= m_due[c]) begin
            m_out[c] = m_tgt[c];
            m_pend[c] = 1'b0;
          end
        end else if (s[c] != m_out[c]) begin
          d = s[c] ? m_rise[c] : m_fall[c];
          m_tgt[c] = s[c];
          if (d == 0) m_out[c] = s[c];
          else begin
            m_pend[c] = 1'b1;
            m_due[c] = cyc + 32'(d);
          end
        end
      end
      if (en && int'(addr) == ABASE + 2 * CH) m_glitch = '0;
      m_glitch = m_glitch | setv;
      if (en) begin
        for (int c = 0; c < CH; c++) begin
          if (int'(addr) == ABASE + 2 * c) m_rise[c] = data;
          if (int'(addr) == ABASE + 2 * c + 1) m_fall[c] = data;
        end
        if (int'(addr) == ABASE + 2 * CH) m_ctrl = data[CH:0];
      end
      m_s2 = m_s1;
      m_s1 = sgn;
    end
  end

  initial forever begin : compare
    @(negedge clk);
    if (cyc > 0) begin
      check("sgn_pre_vs_model", 32'(sgn_pre), 32'(m_out));
      check("busy_vs_model", 32'(busy), 32'(m_pend));
      check("glitch_vs_model", 32'(glitch), 32'(m_glitch));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wr(input int a, input int d);
    @(negedge clk);
    en = 1'b1; addr = ADDR_W'(a); data = DLY_W'(d);
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic drive(input int ch, input logic v);
    @(negedge clk);
    sgn[ch] = v;
  endtask

  // Edges from the first posedge (numbered 'base') until sgn_pre[ch] == v; -1 on timeout.
  task automatic wait_out(input int ch, input logic v, input int base, output int k);
    k = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (sgn_pre[ch] === v) begin
        k = i + base;
        break;
      end
    end
  endtask

  initial begin : stim
    int k;
    int unsigned t_r;
    int busy_cnt, hi_cnt, first_hi;

    repeat (2) @(negedge clk);
    check("reset_sgn_pre", 32'(sgn_pre), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_glitch", 32'(glitch), 0);
    rst = 1'b0;

    // Zero delay.
    drive(0, 1'b1);
    wait_out(0, 1'b1, 0, k);
    check("zero_dly_rise_lat", k, 2);
    check("zero_dly_busy", 32'(busy[0]), 0);
    drive(0, 1'b0);
    wait_out(0, 1'b0, 0, k);
    check("zero_dly_fall_lat", k, 2);

    // rise 5 / fall 2 with a 20-clock pulse.
    wr(ABASE + 0, 5);
    wr(ABASE + 1, 2);
    drive(0, 1'b1);
    wait_out(0, 1'b1, 0, k);
    check("rise5_lat", k, 7);
    t_r = cyc;
    repeat (13) @(negedge clk);
    sgn[0] = 1'b0;
    wait_out(0, 1'b0, 0, k);
    check("fall2_lat", k, 4);
    check("pulse_width", cyc - t_r, 17);

    // Cancelled glitch on channel 1.
    wr(ABASE + 2 * CH, 7);
    wr(ABASE + 2, 10);
    drive(1, 1'b1);
    busy_cnt = 0; hi_cnt = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (busy[1]) busy_cnt++;
      if (sgn_pre[1]) hi_cnt++;
      if (j == 4) sgn[1] = 1'b0;
    end
    check("cancel_busy_clocks", busy_cnt, 4);
    check("cancel_out_high", hi_cnt, 0);
    check("cancel_glitch_set", 32'(glitch[1]), 1);
    wr(ABASE + 2 * CH, 7);
    check("ctrl_wr_clears_glitch", 32'(glitch[1]), 0);

    // Same glitch without cancellation.
    wr(ABASE + 2 * CH, 3);
    drive(1, 1'b1);
    hi_cnt = 0; first_hi = -1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (sgn_pre[1]) begin
        hi_cnt++;
        if (first_hi < 0) first_hi = j;
      end
      if (j == 4) sgn[1] = 1'b0;
    end
    check("nocancel_first_high", first_hi, 13);
    check("nocancel_high_clocks", hi_cnt, 1);
    check("nocancel_glitch", 32'(glitch[1]), 0);

    // Delay write while counting.
    wr(ABASE + 0, 10);
    drive(0, 1'b1);
    repeat (3) @(negedge clk);
    en = 1'b1; addr = ADDR_W'(ABASE + 0); data = 8'd3;
    @(negedge clk);
    en = 1'b0;
    wait_out(0, 1'b1, 4, k);
    check("old_count_kept", k, 12);
    drive(0, 1'b0);
    wait_out(0, 1'b0, 0, k);
    check("fall_after_rewrite", k, 4);
    drive(0, 1'b1);
    wait_out(0, 1'b1, 0, k);
    check("new_rise_dly", k, 5);

    // Disable mid-delay, then re-enable.
    wr(ABASE + 0, 10);
    drive(0, 1'b0);
    wait_out(0, 1'b0, 0, k);
    check("fall_before_disable", k, 4);
    drive(0, 1'b1);
    repeat (4) @(negedge clk);
    en = 1'b1; addr = ADDR_W'(ABASE + 2 * CH); data = 8'd2;
    @(negedge clk);
    en = 1'b0;
    check("busy_before_disable", 32'(busy[0]), 1);
    @(negedge clk);
    check("disable_busy", 32'(busy[0]), 0);
    check("disable_out", 32'(sgn_pre[0]), 0);
    repeat (12) @(negedge clk);
    check("disabled_stays_low", 32'(sgn_pre[0]), 0);
    @(negedge clk);
    en = 1'b1; addr = ADDR_W'(ABASE + 2 * CH); data = 8'd3;
    @(posedge clk);
    #1;
    en = 1'b0;
    wait_out(0, 1'b1, 1, k);
    check("reenable_rise", k, 11);

    // Reset while a falling edge is pending.
    drive(0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_out", 32'(sgn_pre[0]), 0);
    check("rst_mid_busy", 32'(busy[0]), 0);
    rst = 1'b0;

    // Unmapped addresses are ignored; identical stimulus on both channels.
    wr(15, 255);
    wr(0, 255);
    @(negedge clk);
    sgn = 2'b11;
    wait_out(1, 1'b1, 0, k);
    check("ignored_addr_lat", k, 2);
    check("both_channels", 32'(sgn_pre), 3);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
